// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// A fetch entry pairs each returned instruction word with the PC it was fetched from.
package fetch_pkg;

    localparam int unsigned DATA_W        = 32;
    localparam int unsigned INST_BYTES    = 4;
    localparam int unsigned PC_ALIGN_BITS = 2;

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries.
// A flush empties the FIFO and overrides a push or pop issued in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  fetch_entry_t             wdata_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output fetch_entry_t             head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is only observed while count_q is non-zero.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Fetch initiator for a one-cycle-latency instruction memory: owns the PC, pairs returning
// words with their PC, buffers them and hands them to decode; handles redirects and stalls.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     FQ_DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [XLEN-1:0] imem_inst_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            if_valid_o,
    input  logic            if_ready_i,
    output logic [XLEN-1:0] if_pc_o,
    output logic [XLEN-1:0] if_inst_o,
    output logic            misalign_o
);

    localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;

    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic            inflight_q, inflight_d;
    logic            misalign_q, misalign_d;

    logic [CW-1:0]   count;
    fetch_entry_t    head;
    fetch_entry_t    wentry;
    logic            deq, issue, push;

    assign if_valid_o = (count != '0);
    assign deq        = if_valid_o & if_ready_i;
    assign push       = inflight_q & ~redirect_valid_i;

    // Credit check: entries held plus the word on its way back must leave room for one more.
    always_comb begin
        issue = !redirect_valid_i &&
                ((int'(count) + int'(inflight_q) - int'(deq)) < int'(FQ_DEPTH));
    end

    always_comb begin
        req_pc_d   = req_pc_q;
        rsp_pc_d   = rsp_pc_q;
        inflight_d = 1'b0;
        misalign_d = redirect_valid_i && (redirect_pc_i[PC_ALIGN_BITS-1:0] != '0);
        if (redirect_valid_i) begin
            req_pc_d = {redirect_pc_i[XLEN-1:PC_ALIGN_BITS], PC_ALIGN_BITS'(0)};
        end else if (issue) begin
            inflight_d = 1'b1;
            rsp_pc_d   = req_pc_q;
            req_pc_d   = req_pc_q + XLEN'(INST_BYTES);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_pc_q   <= RESET_PC;
            rsp_pc_q   <= '0;
            inflight_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            req_pc_q   <= req_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            misalign_q <= misalign_d;
        end
    end

    assign wentry.pc   = rsp_pc_q;
    assign wentry.inst = imem_inst_i;

    fetch_fifo #(
        .DEPTH (FQ_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .wdata_i (wentry),
        .pop_i   (deq),
        .flush_i (redirect_valid_i),
        .head_o  (head),
        .count_o (count)
    );

    assign imem_addr_o = req_pc_q;
    assign if_pc_o     = if_valid_o ? head.pc : '0;
    assign if_inst_o   = if_valid_o ? head.inst : '0;
    assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus a randomized run against a
// model that tracks only the next PC decode must see and the redirect landing window.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_inst_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        if_valid_o;
    logic        if_ready_i;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        misalign_o;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_pc;

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return 32'h100 + (a >> 2);
    endfunction

    // Memory contents are a pure function of the word address: word i holds 0x100+i.
    always @(posedge clk) imem_inst_i <= inst_of(imem_addr_o);

    inst_fetch #(
        .XLEN     (32),
        .RESET_PC (32'h0),
        .FQ_DEPTH (2)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .imem_addr_o      (imem_addr_o),
        .imem_inst_i      (imem_inst_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .if_valid_o       (if_valid_o),
        .if_ready_i       (if_ready_i),
        .if_pc_o          (if_pc_o),
        .if_inst_o        (if_inst_o),
        .misalign_o       (misalign_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; redirect_valid_i = 1'b0; redirect_pc_i = '0; if_ready_i = 1'b1;
        step(); step();
        n_cmp++;
        if ({imem_addr_o, if_valid_o, if_pc_o, if_inst_o, misalign_o} !== {32'h0, 1'b0, 64'h0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_outputs got addr=%h v=%b pc=%h inst=%h mis=%b want 0/0/0/0/0",
                     imem_addr_o, if_valid_o, if_pc_o, if_inst_o, misalign_o);
        end
        rst_i = 1'b0;
        n_cmp++;
        if ({if_valid_o, imem_addr_o} !== {1'b0, 32'h0}) begin
            n_err++; $display("FAIL release_r got v=%b addr=%h want 0/0", if_valid_o, imem_addr_o);
        end
        step();
        n_cmp++;
        if ({if_valid_o, imem_addr_o} !== {1'b0, 32'h4}) begin
            n_err++; $display("FAIL release_r1 got v=%b addr=%h want 0/4", if_valid_o, imem_addr_o);
        end
        step();
        n_cmp++;
        if ({if_valid_o, if_pc_o, if_inst_o} !== {1'b1, 32'h0, 32'h100}) begin
            n_err++;
            $display("FAIL release_r2 got v=%b pc=%h inst=%h want 1/0/100", if_valid_o, if_pc_o, if_inst_o);
        end
        exp_pc = 32'h4;
        step();
    endtask

    task automatic test_stream(input int n);
        if_ready_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            n_cmp++;
            if ({if_valid_o, if_pc_o, if_inst_o} !== {1'b1, exp_pc, inst_of(exp_pc)}) begin
                n_err++;
                $display("FAIL stream got v=%b pc=%h inst=%h want 1/%h/%h",
                         if_valid_o, if_pc_o, if_inst_o, exp_pc, inst_of(exp_pc));
            end
            exp_pc += 32'h4;
            step();
        end
    endtask

    task automatic test_backpressure();
        // Steady state holds the head plus one word in flight; the next address is head+8.
        if_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({if_valid_o, if_pc_o, if_inst_o, imem_addr_o} !==
                {1'b1, exp_pc, inst_of(exp_pc), exp_pc + 32'h8}) begin
                n_err++;
                $display("FAIL stall_%0d got v=%b pc=%h inst=%h addr=%h want 1/%h/%h/%h", i,
                         if_valid_o, if_pc_o, if_inst_o, imem_addr_o, exp_pc, inst_of(exp_pc),
                         exp_pc + 32'h8);
            end
            step();
        end
        test_stream(8);
    endtask

    task automatic test_redirect_full();
        if_ready_i = 1'b0;
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h40;
        n_cmp++;
        if ({if_valid_o, if_pc_o} !== {1'b1, exp_pc}) begin
            n_err++; $display("FAIL rdf_c got v=%b pc=%h want 1/%h", if_valid_o, if_pc_o, exp_pc);
        end
        step();
        redirect_valid_i = 1'b0; if_ready_i = 1'b1;
        n_cmp++;
        if ({if_valid_o, imem_addr_o, misalign_o} !== {1'b0, 32'h40, 1'b0}) begin
            n_err++;
            $display("FAIL rdf_c1 got v=%b addr=%h mis=%b want 0/40/0", if_valid_o, imem_addr_o, misalign_o);
        end
        step();
        n_cmp++;
        if (if_valid_o !== 1'b0) begin
            n_err++; $display("FAIL rdf_c2 got v=%b want 0", if_valid_o);
        end
        step();
        n_cmp++;
        if ({if_valid_o, if_pc_o, if_inst_o} !== {1'b1, 32'h40, 32'h110}) begin
            n_err++;
            $display("FAIL rdf_c3 got v=%b pc=%h inst=%h want 1/40/110", if_valid_o, if_pc_o, if_inst_o);
        end
        exp_pc = 32'h44;
        step();
    endtask

    task automatic test_redirect_deq();
        rst_i = 1'b1; if_ready_i = 1'b1; redirect_valid_i = 1'b0;
        step(); step();
        rst_i = 1'b0;
        step(); step();
        exp_pc = 32'h0;
        test_stream(2);
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h200;
        n_cmp++;
        if ({if_valid_o, if_pc_o, if_inst_o} !== {1'b1, 32'h8, 32'h102}) begin
            n_err++;
            $display("FAIL rdq_c got v=%b pc=%h inst=%h want 1/8/102", if_valid_o, if_pc_o, if_inst_o);
        end
        step();
        redirect_valid_i = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            n_cmp++;
            if (if_valid_o !== 1'b0) begin
                n_err++; $display("FAIL rdq_c%0d got v=%b pc=%h want 0", i, if_valid_o, if_pc_o);
            end
            step();
        end
        n_cmp++;
        if ({if_valid_o, if_pc_o, if_inst_o} !== {1'b1, 32'h200, 32'h180}) begin
            n_err++;
            $display("FAIL rdq_c3 got v=%b pc=%h inst=%h want 1/200/180", if_valid_o, if_pc_o, if_inst_o);
        end
        exp_pc = 32'h204;
        step();
    endtask

    task automatic test_misalign();
        if_ready_i = 1'b1;
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h42;
        step();
        redirect_valid_i = 1'b0;
        n_cmp++;
        if ({misalign_o, imem_addr_o} !== {1'b1, 32'h40}) begin
            n_err++; $display("FAIL mis_c1 got mis=%b addr=%h want 1/40", misalign_o, imem_addr_o);
        end
        step();
        n_cmp++;
        if ({misalign_o, if_valid_o} !== 2'b00) begin
            n_err++; $display("FAIL mis_c2 got mis=%b v=%b want 0/0", misalign_o, if_valid_o);
        end
        step();
        n_cmp++;
        if ({if_valid_o, if_pc_o} !== {1'b1, 32'h40}) begin
            n_err++; $display("FAIL mis_c3 got v=%b pc=%h want 1/40", if_valid_o, if_pc_o);
        end
        step();
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h80;
        step();
        redirect_pc_i = 32'hC0;
        n_cmp++;
        if ({if_valid_o, misalign_o} !== 2'b00) begin
            n_err++; $display("FAIL b2b_1 got v=%b mis=%b want 0/0", if_valid_o, misalign_o);
        end
        step();
        redirect_valid_i = 1'b0;
        n_cmp++;
        if ({if_valid_o, imem_addr_o} !== {1'b0, 32'hC0}) begin
            n_err++; $display("FAIL b2b_2 got v=%b addr=%h want 0/c0", if_valid_o, imem_addr_o);
        end
        step();
        n_cmp++;
        if (if_valid_o !== 1'b0) begin
            n_err++; $display("FAIL b2b_3 got v=%b pc=%h want 0", if_valid_o, if_pc_o);
        end
        step();
        n_cmp++;
        if ({if_valid_o, if_pc_o, if_inst_o} !== {1'b1, 32'hC0, 32'h130}) begin
            n_err++;
            $display("FAIL b2b_4 got v=%b pc=%h inst=%h want 1/c0/130", if_valid_o, if_pc_o, if_inst_o);
        end
        exp_pc = 32'hC4;
        step();
    endtask

    task automatic test_wrap();
        if_ready_i = 1'b1;
        redirect_valid_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF8;
        step();
        redirect_valid_i = 1'b0;
        step(); step();
        exp_pc = 32'hFFFF_FFF8;
        test_stream(5);
        n_cmp++;
        if (exp_pc !== 32'hC || if_pc_o !== 32'hC) begin
            n_err++; $display("FAIL wrap_end got pc=%h want c", if_pc_o);
        end
    endtask

    task automatic test_reset_mid();
        if_ready_i = 1'b1;
        rst_i = 1'b1; redirect_valid_i = 1'b1; redirect_pc_i = 32'h300;
        step();
        redirect_valid_i = 1'b0;
        n_cmp++;
        if ({if_valid_o, imem_addr_o, if_pc_o, if_inst_o} !== {1'b0, 96'h0}) begin
            n_err++;
            $display("FAIL rstmid got v=%b addr=%h pc=%h inst=%h want 0/0/0/0",
                     if_valid_o, imem_addr_o, if_pc_o, if_inst_o);
        end
        rst_i = 1'b0;
        step(); step();
        n_cmp++;
        if ({if_valid_o, if_pc_o, if_inst_o} !== {1'b1, 32'h0, 32'h100}) begin
            n_err++;
            $display("FAIL rstmid_r2 got v=%b pc=%h inst=%h want 1/0/100", if_valid_o, if_pc_o, if_inst_o);
        end
        exp_pc = 32'h4;
        step();
    endtask

    task automatic test_random(input int n);
        int          since = 0;
        logic        prev_held = 1'b0;
        logic        prev_mis = 1'b0;
        logic        rdy, redir, deq;
        logic [31:0] tgt;
        for (int i = 0; i < n; i++) begin
            rdy   = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 15) == 0);
            tgt   = $urandom;
            if_ready_i = rdy; redirect_valid_i = redir; redirect_pc_i = tgt;
            n_cmp++;
            if (misalign_o !== prev_mis) begin
                n_err++; $display("FAIL rnd_mis cyc %0d got %b want %b", i, misalign_o, prev_mis);
            end
            if (since == 1 || since == 2) begin
                n_cmp++;
                if (if_valid_o !== 1'b0) begin
                    n_err++; $display("FAIL rnd_gap cyc %0d got v=%b pc=%h want 0", i, if_valid_o, if_pc_o);
                end
            end else if (since == 3 || prev_held) begin
                n_cmp++;
                if (if_valid_o !== 1'b1) begin
                    n_err++; $display("FAIL rnd_valid cyc %0d got v=%b want 1", i, if_valid_o);
                end
            end
            if (if_valid_o === 1'b1) begin
                n_cmp++;
                if ({if_pc_o, if_inst_o} !== {exp_pc, inst_of(exp_pc)}) begin
                    n_err++;
                    $display("FAIL rnd_head cyc %0d got pc=%h inst=%h want %h/%h",
                             i, if_pc_o, if_inst_o, exp_pc, inst_of(exp_pc));
                end
            end
            deq = (if_valid_o === 1'b1) && rdy;
            if (deq) exp_pc += 32'h4;
            prev_held = (if_valid_o === 1'b1) && !rdy && !redir;
            prev_mis  = redir && (tgt[1:0] != 2'b00);
            if (redir) begin
                exp_pc = {tgt[31:2], 2'b00};
                since  = 1;
            end else if (since != 0) begin
                since = (since == 3) ? 0 : since + 1;
            end
            step();
        end
        redirect_valid_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; redirect_valid_i = 1'b0; redirect_pc_i = '0; if_ready_i = 1'b0;
        exp_pc = '0;
        test_reset();
        test_stream(12);
        test_backpressure();
        test_redirect_full();
        test_stream(4);
        test_redirect_deq();
        test_stream(3);
        test_misalign();
        test_wrap();
        test_reset_mid();
        test_stream(4);
        test_random(600);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
